// File: rtl/sram_playback_engine.sv
// Record/playback sequencer between the codec sample stream and an SRAM port.
// Define LOOP_PLAYBACK_EN to wrap playback to address 0 instead of stopping at end of data.
module sram_playback_engine #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int RATIO_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  logic                record,
  input  logic                play,
  input  logic                pause,
  input  logic                stop,
  input  logic                slow,
  input  logic                normal,
  input  logic                interp,
  input  logic [RATIO_W-1:0]  ratio_m1,
  input  logic [DATA_W-1:0]   adc_sample,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic [DATA_W-1:0]   dac_sample,
  output logic                dac_valid,
  output logic [ADDR_W-1:0]   cur_addr,
  output logic [ADDR_W:0]     rec_len,
  output logic                overrun,
  output logic [1:0]          state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REC    = 2'd1;
  localparam logic [1:0] S_PLAY   = 2'd2;
  localparam logic [1:0] S_PAUSED = 2'd3;
  localparam int AW1 = ADDR_W + 1;
  localparam int PW  = DATA_W + RATIO_W + 12;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0]  prev, curr, slow_out;
  logic [RATIO_W-1:0] k, n_m1_q;
  logic               slow_q, interp_q, stop_pend, play_arm, clr_dac;
  logic [1:0]         pause_ret;
  logic [8:0]         r_val;
  logic [ADDR_W:0]    next_addr;

  function automatic logic [DATA_W-1:0] lerp(input logic [DATA_W-1:0] p, c,
                                             input logic [RATIO_W-1:0] kk,
                                             input logic [8:0] r);
    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod;
    diff = $signed({c[DATA_W-1], c}) - $signed({p[DATA_W-1], p});
    prod = PW'(diff) * PW'($signed({1'b0, kk})) * PW'($signed({1'b0, r}));
    return p + DATA_W'(prod >>> 8);
  endfunction

  // round(256/N) table, unrolled into constants
  always_comb begin
    r_val = '0;
    for (int unsigned i = 0; i < (1 << RATIO_W); i++)
      if (n_m1_q == RATIO_W'(i)) r_val = 9'((512 + i + 1) / (2 * i + 2));
  end

  always_comb begin
    next_addr = {1'b0, cur_addr} + (slow_q ? AW1'(1) : AW1'(n_m1_q) + AW1'(1));
    slow_out  = interp_q ? lerp(prev, curr, k, r_val) : curr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;      pause_ret <= S_IDLE;
      mem_req <= 1'b0;      mem_we <= 1'b0;
      mem_addr <= '0;       mem_wdata <= '0;
      dac_sample <= '0;     dac_valid <= 1'b0;
      cur_addr <= '0;       rec_len <= '0;
      overrun <= 1'b0;      prev <= '0;
      curr <= '0;           k <= '0;
      n_m1_q <= '0;         slow_q <= 1'b0;
      interp_q <= 1'b0;     stop_pend <= 1'b0;
      play_arm <= 1'b0;     clr_dac <= 1'b0;
    end else begin
      dac_valid <= 1'b0;
      overrun   <= 1'b0;
      clr_dac   <= 1'b0;
      if (clr_dac) dac_sample <= '0;
      if (!play) play_arm <= 1'b1;

      if (mem_req) begin
        if (sample_tick) overrun <= 1'b1;
        if (stop) stop_pend <= 1'b1;
        if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          if (stop_pend || stop) begin
            stop_pend  <= 1'b0;
            state      <= S_IDLE;
            cur_addr   <= '0;
            dac_sample <= '0;
            if (mem_we) rec_len <= rec_len + 1'b1;
          end else if (mem_we) begin
            rec_len <= rec_len + 1'b1;
            if (cur_addr != '1) cur_addr <= cur_addr + 1'b1;
          end else begin
            dac_valid <= 1'b1;
            if (slow_q) begin
              prev       <= curr;
              curr       <= mem_rdata;
              dac_sample <= interp_q ? curr : mem_rdata;
              k          <= (n_m1_q == '0) ? '0 : RATIO_W'(1);
            end else begin
              dac_sample <= mem_rdata;
            end
            // the final sample is still presented; the clear lands one cycle later
            if (next_addr >= rec_len) begin
              cur_addr <= '0;
`ifdef LOOP_PLAYBACK_EN
              prev <= '0;
              curr <= '0;
              k    <= '0;
`else
              state   <= S_IDLE;
              clr_dac <= 1'b1;
              k       <= '0;
`endif
            end else begin
              cur_addr <= next_addr[ADDR_W-1:0];
            end
          end
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (stop) begin
              cur_addr <= '0;
            end else if (record) begin
              state    <= S_REC;
              cur_addr <= '0;
              rec_len  <= '0;
            end else if (play && play_arm && rec_len != '0) begin
              state    <= S_PLAY;
              play_arm <= 1'b0;
              cur_addr <= '0;
              prev     <= '0;
              curr     <= '0;
              k        <= '0;
            end
          end
          S_REC, S_PLAY: begin
            if (stop) begin
              state      <= S_IDLE;
              cur_addr   <= '0;
              dac_sample <= '0;
            end else if (pause) begin
              pause_ret <= state;
              state     <= S_PAUSED;
              if (sample_tick) begin
                dac_valid  <= 1'b1;
                dac_sample <= '0;
              end
            end else if (state == S_REC) begin
              if (!record) begin
                state <= S_IDLE;
              end else if (sample_tick && rec_len != FULL) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= cur_addr;
                mem_wdata <= adc_sample;
              end
            end else if (!play) begin
              state      <= S_IDLE;
              cur_addr   <= '0;
              dac_sample <= '0;
            end else if (sample_tick) begin
              // mode and ratio are only re-sampled when a new source sample is fetched
              if (k != '0) begin
                dac_valid  <= 1'b1;
                dac_sample <= slow_out;
                k          <= (k == n_m1_q) ? '0 : k + 1'b1;
              end else begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= cur_addr;
                slow_q   <= slow & ~normal;
                n_m1_q   <= normal ? '0 : ratio_m1;
                interp_q <= interp;
              end
            end
          end
          default: begin
            if (stop) begin
              state      <= S_IDLE;
              cur_addr   <= '0;
              dac_sample <= '0;
            end else if (!pause) begin
              state <= pause_ret;
            end else if (sample_tick) begin
              dac_valid  <= 1'b1;
              dac_sample <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_playback_engine.sv
// Directed and randomized bench for sram_playback_engine with an SRAM responder and a sample-sequence model.
module tb_sram_playback_engine;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int RW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, sample_tick, record, play, pause, stop, slow, normal, interp;
  logic [RW-1:0] ratio_m1;
  logic [DW-1:0] adc_sample, mem_wdata, mem_rdata, dac_sample;
  logic          mem_req, mem_we, mem_ack, dac_valid, overrun;
  logic [AW-1:0] mem_addr, cur_addr;
  logic [AW:0]   rec_len;
  logic [1:0]    state;

  sram_playback_engine #(.ADDR_W(AW), .DATA_W(DW), .RATIO_W(RW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .record(record),
    .play(play), .pause(pause), .stop(stop), .slow(slow), .normal(normal),
    .interp(interp), .ratio_m1(ratio_m1), .adc_sample(adc_sample),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dac_sample(dac_sample),
    .dac_valid(dac_valid), .cur_addr(cur_addr), .rec_len(rec_len),
    .overrun(overrun), .state(state)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            lat      = 2;
  int            ovr_cnt  = 0;
  logic [DW-1:0] mem_model [16];
  logic [DW-1:0] dac_q[$], exp_q[$], rec_vals[$], wd_q[$];
  logic [AW-1:0] wa_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // SRAM responder: acks lat cycles after a request appears
  initial begin : responder
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req === 1'b1) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
          end else mem_rdata = mem_model[mem_addr];
        end
      end else cnt = 0;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (dac_valid === 1'b1) dac_q.push_back(dac_sample);
      if (overrun === 1'b1) ovr_cnt++;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    wait_cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic record_all();
    wa_q.delete();
    wd_q.delete();
    record = 1'b1;
    wait_cyc(2);
    foreach (rec_vals[i]) begin
      adc_sample = rec_vals[i];
      pulse_tick();
      wait_cyc(lat + 3);
    end
    record = 1'b0;
    wait_cyc(2);
  endtask

  task automatic build_model(input int n, input bit slowm, input bit interpm);
    int len;
    len = rec_vals.size();
    exp_q.delete();
    if (!slowm) begin
      for (int a = 0; a < len; a += n) exp_q.push_back(rec_vals[a]);
    end else begin
      for (int i = 0; i < len; i++) begin
        int p, c, kmax, r;
        p = (i == 0) ? 0 : int'($signed(rec_vals[i-1]));
        c = int'($signed(rec_vals[i]));
        kmax = (i == len - 1) ? 1 : n;
        r = $rtoi(256.0 / n + 0.5);
        for (int kk = 0; kk < kmax; kk++)
          exp_q.push_back(interpm ? DW'(p + (((c - p) * kk * r) >>> 8)) : DW'(c));
      end
    end
  endtask

  task automatic play_run(input string tag, input int max_ticks);
    int nt;
    nt = 0;
    dac_q.delete();
    play = 1'b1;
    wait_cyc(2);
    check({tag, "_enter_play"}, 32'(state), 32'd2);
    while (state == 2'd2 && dac_q.size() < exp_q.size() && nt < max_ticks) begin
      pulse_tick();
      wait_cyc(lat + 3);
      nt++;
    end
`ifdef LOOP_PLAYBACK_EN
    check({tag, "_end_state"}, 32'(state), 32'd2);
`else
    check({tag, "_end_state"}, 32'(state), 32'd0);
`endif
    play = 1'b0;
    wait_cyc(2);
  endtask

  task automatic compare_dac(input string tag);
    check({tag, "_count"}, 32'(dac_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < dac_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_dac%0d", tag, i), 32'(dac_q[i]), 32'(exp_q[i]));
  endtask

  initial begin : stim
    int n;
    bit sm, im;
    int first_interp[4];
    first_interp = '{0, 200, 400, 600};

    reset_n = 1'b0; sample_tick = 1'b0; record = 1'b0; play = 1'b0; pause = 1'b0;
    stop = 1'b0; slow = 1'b0; normal = 1'b0; interp = 1'b0; ratio_m1 = '0; adc_sample = '0;
    wait_cyc(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_cur_addr", 32'(cur_addr), 32'd0);
    check("rst_rec_len", 32'(rec_len), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_dac_valid", 32'(dac_valid), 32'd0);
    check("rst_dac_sample", 32'(dac_sample), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    wait_cyc(2);

    // record four samples
    lat = 2;
    rec_vals = '{16'd100, 16'd200, 16'd300, 16'd400};
    record_all();
    check("rec_writes", 32'(wa_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      check($sformatf("rec_addr%0d", i), 32'(wa_q[i]), 32'(i));
      check($sformatf("rec_data%0d", i), 32'(wd_q[i]), 32'(rec_vals[i]));
    end
    check("rec_len4", 32'(rec_len), 32'd4);
    check("rec_idle", 32'(state), 32'd0);

    // fast playback, N=2
    ratio_m1 = 3'd1; slow = 1'b0; normal = 1'b0;
    build_model(2, 1'b0, 1'b0);
    play_run("fast2", 20);
    compare_dac("fast2");
`ifndef LOOP_PLAYBACK_EN
    check("fast2_cur_addr", 32'(cur_addr), 32'd0);
    check("fast2_dac_clear", 32'(dac_sample), 32'd0);
`endif

    // slow playback, N=4, with and without interpolation
    rec_vals = '{16'd800, 16'hFE70, 16'd1000};
    record_all();
    ratio_m1 = 3'd3; slow = 1'b1; interp = 1'b1;
    build_model(4, 1'b1, 1'b1);
    play_run("slow_i", 40);
    compare_dac("slow_i");
    for (int i = 0; i < 4 && i < dac_q.size(); i++)
      check($sformatf("slow_i_first%0d", i), 32'(dac_q[i]), 32'(DW'(first_interp[i])));
    interp = 1'b0;
    build_model(4, 1'b1, 1'b0);
    play_run("slow_r", 40);
    compare_dac("slow_r");
    for (int i = 0; i < 4 && i < dac_q.size(); i++)
      check($sformatf("slow_r_first%0d", i), 32'(dac_q[i]), 32'd800);

    // tick while a read is outstanding
    rec_vals = '{16'd11, 16'd22, 16'd33};
    record_all();
    slow = 1'b0; ratio_m1 = '0; lat = 5;
    dac_q.delete();
    ovr_cnt = 0;
    play = 1'b1;
    wait_cyc(2);
    pulse_tick();
    wait_cyc(1);
    pulse_tick();
    wait_cyc(8);
    check("ovr_pulses", 32'(ovr_cnt), 32'd1);
    check("ovr_dac_count", 32'(dac_q.size()), 32'd1);
    if (dac_q.size() > 0) check("ovr_dac", 32'(dac_q[0]), 32'd11);
    check("ovr_cur_addr", 32'(cur_addr), 32'd1);
    play = 1'b0;
    lat = 2;
    wait_cyc(2);

    // pause, resume, then stop with a read pending
    rec_vals = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
    record_all();
    play = 1'b1;
    wait_cyc(2);
    repeat (2) begin pulse_tick(); wait_cyc(lat + 3); end
    check("pause_pre_addr", 32'(cur_addr), 32'd2);
    pause = 1'b1;
    wait_cyc(2);
    check("pause_state", 32'(state), 32'd3);
    dac_q.delete();
    repeat (3) begin pulse_tick(); wait_cyc(3); end
    check("pause_dac_count", 32'(dac_q.size()), 32'd3);
    foreach (dac_q[i]) check($sformatf("pause_dac%0d", i), 32'(dac_q[i]), 32'd0);
    check("pause_addr_frozen", 32'(cur_addr), 32'd2);
    pause = 1'b0;
    wait_cyc(2);
    check("resume_state", 32'(state), 32'd2);
    dac_q.delete();
    pulse_tick();
    wait_cyc(lat + 3);
    check("resume_dac_count", 32'(dac_q.size()), 32'd1);
    if (dac_q.size() > 0) check("resume_dac", 32'(dac_q[0]), 32'd7);
    check("resume_addr", 32'(cur_addr), 32'd3);
    lat = 5;
    pulse_tick();
    stop = 1'b1;
    wait_cyc(1);
    stop = 1'b0;
    check("stop_req_held", 32'(mem_req), 32'd1);
    check("stop_state_held", 32'(state), 32'd2);
    dac_q.delete();
    wait_cyc(8);
    check("stop_state", 32'(state), 32'd0);
    check("stop_cur_addr", 32'(cur_addr), 32'd0);
    check("stop_dac_sample", 32'(dac_sample), 32'd0);
    check("stop_no_dac", 32'(dac_q.size()), 32'd0);
    play = 1'b0;
    lat = 1;
    wait_cyc(2);

    // fill the whole memory; extra ticks are ignored
    rec_vals.delete();
    repeat (18) rec_vals.push_back(DW'($urandom));
    record_all();
    check("full_writes", 32'(wa_q.size()), 32'd16);
    check("full_rec_len", 32'(rec_len), 32'd16);
    check("full_cur_addr", 32'(cur_addr), 32'd15);
    if (wd_q.size() == 16) check("full_last_data", 32'(wd_q[15]), 32'(rec_vals[15]));
    rec_vals = rec_vals[0:15];
    ratio_m1 = 3'd2; slow = 1'b0;
    build_model(3, 1'b0, 1'b0);
    play_run("full_fast3", 30);
    compare_dac("full_fast3");

    // randomized record/playback sessions
    for (int it = 0; it < 6; it++) begin
      lat = $urandom_range(1, 3);
      rec_vals.delete();
      repeat ($urandom_range(1, 10)) rec_vals.push_back(DW'($urandom));
      record_all();
      n = $urandom_range(1, 8);
      ratio_m1 = RW'(n - 1);
      slow = 1'($urandom);
      interp = 1'($urandom);
      normal = ($urandom_range(0, 3) == 0);
      sm = slow && !normal;
      im = interp;
      if (normal) n = 1;
      build_model(n, sm, im);
      play_run($sformatf("rnd%0d", it), 100);
      compare_dac($sformatf("rnd%0d", it));
    end
    normal = 1'b0; slow = 1'b0; interp = 1'b0; lat = 2;

`ifdef LOOP_PLAYBACK_EN
    rec_vals = '{16'd100, 16'd200};
    record_all();
    normal = 1'b1;
    dac_q.delete();
    play = 1'b1;
    wait_cyc(2);
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      wait_cyc(lat + 3);
      check($sformatf("loop_state%0d", i), 32'(state), 32'd2);
    end
    exp_q = '{16'd100, 16'd200, 16'd100, 16'd200};
    compare_dac("loop");
    play = 1'b0;
    normal = 1'b0;
    wait_cyc(2);
    check("loop_exit", 32'(state), 32'd0);
`endif

    // asynchronous reset in the middle of a read
    rec_vals = '{16'd1, 16'd2};
    record_all();
    lat = 6;
    play = 1'b1;
    wait_cyc(2);
    pulse_tick();
    wait_cyc(2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_cur_addr", 32'(cur_addr), 32'd0);
    check("arst_rec_len", 32'(rec_len), 32'd0);
    check("arst_dac_sample", 32'(dac_sample), 32'd0);
    check("arst_dac_valid", 32'(dac_valid), 32'd0);
    play = 1'b0;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
